hazard_ctrl: RTL and testbench

//  ID-stage hazard controller for the 5-stage RV32I pipeline: generates clearcontrol (consumed by the ID control decoder),
//  PC / IF-ID write enables, the IF-ID flush and the freeze used while data memory is busy.

---
 rtl/hazard_ctrl_pkg.sv | 35 +++
 rtl/hazard_ctrl_sat_counter.sv | 27 ++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the ID-stage hazard controller.
//   - RV32I major opcode constants (7-bit)
//   - hazard FSM state encoding (HZ_RUN / HZ_FLUSH / HZ_MEMWAIT)
//   - source-register usage decode helpers
package hazard_ctrl_pkg;

    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_FLUSH   = 2'd1,
        HZ_MEMWAIT = 2'd2
    } hz_state_e;

    // Non-32-bit encodings (opcode[1:0] != 2'b11) read no registers.
    function automatic logic uses_rs1(input logic [OPCODE_W-1:0] op);
        return (op[1:0] == 2'b11) && (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [OPCODE_W-1:0] op);
        return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: synchronous up-counter that sticks at all-ones.
//   i_clk   clock
//   i_rst   synchronous active-high clear
//   i_inc   count enable
//   o_count current count
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard controller for the 5-stage RV32I pipeline.
// Handles load-use stalls, taken-branch/jump flushes and dmem wait freezes,
// and keeps saturating stall / flush performance counters.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_id_opcode/_rs1/_rs2        instruction currently in ID
//   i_ex_memread, i_ex_rd        load in EX and its destination
//   i_ex_pcsrc                   EX resolved a taken branch / jump
//   i_dmem_req, i_dmem_ready     outstanding dmem access / completes this cycle
//   o_clearcontrol               bubble into ID/EX
//   o_pcwrite, o_ifid_write      PC and IF/ID write enables
//   o_ifid_flush                 squash IF/ID to NOP
//   o_pipe_freeze                hold ID/EX, EX/MEM, MEM/WB
//   o_stall_count, o_flush_count saturating performance counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH   = OPCODE_W,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned FLUSH_CYCLES   = 1,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [OPCODE_WIDTH-1:0]   i_id_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
    input  logic                      i_ex_memread,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
    input  logic                      i_ex_pcsrc,
    input  logic                      i_dmem_req,
    input  logic                      i_dmem_ready,
    output logic                      o_clearcontrol,
    output logic                      o_pcwrite,
    output logic                      o_ifid_write,
    output logic                      o_ifid_flush,
    output logic                      o_pipe_freeze,
    output logic [CNT_WIDTH-1:0]      o_stall_count,
    output logic [CNT_WIDTH-1:0]      o_flush_count
);

    localparam int unsigned FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    hz_state_e       r_state, w_state_nxt;
    hz_state_e       r_saved, w_saved_nxt;  // state to resume after MEMWAIT
    hz_state_e       w_cur;
    logic [FL_W-1:0] r_flush_left, w_flush_left_nxt;

    logic w_use_rs1, w_use_rs2, w_load_use, w_mem_wait;
    logic w_stall_inc, w_flush_inc;

    assign w_use_rs1  = uses_rs1(i_id_opcode);
    assign w_use_rs2  = uses_rs2(i_id_opcode);
    assign w_load_use = i_ex_memread && (i_ex_rd != '0) &&
                        ((w_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                         (w_use_rs2 && (i_id_rs2 == i_ex_rd)));
    assign w_mem_wait = i_dmem_req && !i_dmem_ready;

    // On the release cycle of a dmem wait, act as the state that was interrupted.
    assign w_cur = (r_state == HZ_MEMWAIT) ? r_saved : r_state;

    always_comb begin
        w_state_nxt      = r_state;
        w_saved_nxt      = r_saved;
        w_flush_left_nxt = r_flush_left;
        w_stall_inc      = 1'b0;
        w_flush_inc      = 1'b0;
        o_clearcontrol   = 1'b0;
        o_pcwrite        = 1'b1;
        o_ifid_write     = 1'b1;
        o_ifid_flush     = 1'b0;
        o_pipe_freeze    = 1'b0;

        if (i_rst) begin
            o_clearcontrol = 1'b1;
            o_pcwrite      = 1'b0;
            o_ifid_write   = 1'b0;
            o_ifid_flush   = 1'b1;
            w_state_nxt    = HZ_RUN;
        end else if (w_mem_wait) begin
            o_pipe_freeze = 1'b1;
            o_pcwrite     = 1'b0;
            o_ifid_write  = 1'b0;
            w_stall_inc   = 1'b1;
            if (r_state != HZ_MEMWAIT) begin
                w_saved_nxt = r_state;
            end
            w_state_nxt = HZ_MEMWAIT;
        end else if (i_ex_pcsrc) begin
            o_clearcontrol = 1'b1;
            o_ifid_flush   = 1'b1;
            w_flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt      = HZ_FLUSH;
                w_flush_left_nxt = FL_W'(FLUSH_CYCLES - 1);
            end else begin
                w_state_nxt = HZ_RUN;
            end
        end else if (w_cur == HZ_FLUSH) begin
            o_clearcontrol   = 1'b1;
            o_ifid_flush     = 1'b1;
            w_flush_left_nxt = r_flush_left - 1'b1;
            w_state_nxt      = (r_flush_left <= FL_W'(1)) ? HZ_RUN : HZ_FLUSH;
        end else if (w_load_use) begin
            o_clearcontrol = 1'b1;
            o_pcwrite      = 1'b0;
            o_ifid_write   = 1'b0;
            w_stall_inc    = 1'b1;
            w_state_nxt    = HZ_RUN;
        end else begin
            w_state_nxt = HZ_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= HZ_RUN;
            r_saved      <= HZ_RUN;
            r_flush_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_saved      <= w_saved_nxt;
            r_flush_left <= w_flush_left_nxt;
        end
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (w_stall_inc),
        .o_count(o_stall_count)
    );

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_flush_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (w_flush_inc),
        .o_count(o_flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl.
// Main DUT uses FLUSH_CYCLES=2; a second instance (FLUSH_CYCLES=1, CNT_WIDTH=2)
// shares the stimulus and covers single-bubble flushes and counter saturation.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    // Expected control vector order: {clearcontrol, pcwrite, ifid_write, ifid_flush, pipe_freeze}
    localparam logic [4:0] EXP_NORM   = 5'b01100;
    localparam logic [4:0] EXP_STALL  = 5'b10000;
    localparam logic [4:0] EXP_FLUSH  = 5'b11110;
    localparam logic [4:0] EXP_FREEZE = 5'b00001;
    localparam logic [4:0] EXP_RST    = 5'b10010;

    logic       clk, rst;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_memread, ex_pcsrc, dmem_req, dmem_ready;

    logic        m_clr, m_pcw, m_ifw, m_flush, m_frz;
    logic [31:0] m_stall, m_fcnt;
    logic        s_clr, s_pcw, s_ifw, s_flush, s_frz;
    logic [1:0]  s_stall, s_fcnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];

    hazard_ctrl #(
        .FLUSH_CYCLES(2),
        .CNT_WIDTH   (32)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_id_opcode   (id_opcode),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_ex_memread  (ex_memread),
        .i_ex_rd       (ex_rd),
        .i_ex_pcsrc    (ex_pcsrc),
        .i_dmem_req    (dmem_req),
        .i_dmem_ready  (dmem_ready),
        .o_clearcontrol(m_clr),
        .o_pcwrite     (m_pcw),
        .o_ifid_write  (m_ifw),
        .o_ifid_flush  (m_flush),
        .o_pipe_freeze (m_frz),
        .o_stall_count (m_stall),
        .o_flush_count (m_fcnt)
    );

    hazard_ctrl #(
        .FLUSH_CYCLES(1),
        .CNT_WIDTH   (2)
    ) u_dut_small (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_id_opcode   (id_opcode),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_ex_memread  (ex_memread),
        .i_ex_rd       (ex_rd),
        .i_ex_pcsrc    (ex_pcsrc),
        .i_dmem_req    (dmem_req),
        .i_dmem_ready  (dmem_ready),
        .o_clearcontrol(s_clr),
        .o_pcwrite     (s_pcw),
        .o_ifid_write  (s_ifw),
        .o_ifid_flush  (s_flush),
        .o_pipe_freeze (s_frz),
        .o_stall_count (s_stall),
        .o_flush_count (s_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle at the negedge, queue the expectation, compare before the posedge.
    task automatic step(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic mr, input logic [4:0] rd, input logic pc,
                        input logic dq, input logic dr, input logic r,
                        input logic [4:0] exp, input string name);
        logic [4:0] want;
        @(negedge clk);
        id_opcode  = op;
        id_rs1     = rs1;
        id_rs2     = rs2;
        ex_memread = mr;
        ex_rd      = rd;
        ex_pcsrc   = pc;
        dmem_req   = dq;
        dmem_ready = dr;
        rst        = r;
        exp_q.push_back(exp);
        #1;
        want = exp_q.pop_front();
        check(name, {27'd0, m_clr, m_pcw, m_ifw, m_flush, m_frz}, {27'd0, want});
    endtask

    task automatic idle(input logic [4:0] exp, input string name);
        step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp, name);
    endtask

    task automatic do_reset(input string name);
        step(OP_IMM, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, EXP_RST, name);
    endtask

    // Counters update on the posedge following the current step.
    task automatic check_counts(input string name, input int st, input int fl);
        @(posedge clk);
        #1;
        check({name, "_stall"}, m_stall, st);
        check({name, "_flush"}, m_fcnt, fl);
    endtask

    initial begin
        rst = 1'b1; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; ex_memread = 1'b0;
        ex_rd = '0; ex_pcsrc = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

        vecs[0]  = '{OP_REG,    5'd5, 5'd7, 1'b1, 5'd5, EXP_STALL};
        vecs[1]  = '{OP_REG,    5'd1, 5'd5, 1'b1, 5'd5, EXP_STALL};
        vecs[2]  = '{OP_LUI,    5'd5, 5'd5, 1'b1, 5'd5, EXP_NORM};
        vecs[3]  = '{OP_REG,    5'd0, 5'd0, 1'b1, 5'd0, EXP_NORM};
        vecs[4]  = '{OP_STORE,  5'd1, 5'd5, 1'b1, 5'd5, EXP_STALL};
        vecs[5]  = '{OP_IMM,    5'd2, 5'd5, 1'b1, 5'd5, EXP_NORM};
        vecs[6]  = '{OP_IMM,    5'd5, 5'd0, 1'b0, 5'd5, EXP_NORM};
        vecs[7]  = '{OP_BRANCH, 5'd3, 5'd9, 1'b1, 5'd9, EXP_STALL};
        vecs[8]  = '{OP_JAL,    5'd9, 5'd9, 1'b1, 5'd9, EXP_NORM};
        vecs[9]  = '{OP_JALR,   5'd9, 5'd0, 1'b1, 5'd9, EXP_STALL};
        vecs[10] = '{7'b0000000, 5'd9, 5'd9, 1'b1, 5'd9, EXP_NORM};
        vecs[11] = '{OP_IMM,    5'd4, 5'd5, 1'b1, 5'd5, EXP_NORM};

        // Reset state
        do_reset("reset_outputs");
        check_counts("reset", 0, 0);

        // Load-use: one bubble, then normal once EX holds the bubble
        step(OP_REG, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, EXP_STALL, "lu_add");
        check_counts("lu_add", 1, 0);
        step(OP_REG, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_NORM, "lu_after");

        // Register-usage table
        do_reset("reset_tbl");
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].mr, vecs[i].rd,
                 1'b0, 1'b0, 1'b0, 1'b0, vecs[i].exp, $sformatf("tbl%0d", i));
        end
        check_counts("tbl", 5, 0);

        // Two-bubble flush; small instance releases after one
        do_reset("reset_fl");
        step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_FLUSH, "fl_n");
        idle(EXP_FLUSH, "fl_n1");
        check("fl_small_n1", {27'd0, s_clr, s_pcw, s_ifw, s_flush, s_frz}, {27'd0, EXP_NORM});
        idle(EXP_NORM, "fl_n2");
        check_counts("fl", 0, 1);

        // Restart: ex_pcsrc during FLUSH reloads the bubble count
        do_reset("reset_rs");
        step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_FLUSH, "rs_0");
        step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_FLUSH, "rs_1");
        idle(EXP_FLUSH, "rs_2");
        idle(EXP_NORM, "rs_3");
        check_counts("rs", 0, 2);

        // dmem wait with pending branch: freeze 3 cycles, flush on release
        do_reset("reset_mw");
        for (int i = 0; i < 3; i++) begin
            step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, EXP_FREEZE,
                 $sformatf("mw_frz%0d", i));
        end
        step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, EXP_FLUSH, "mw_rel");
        idle(EXP_FLUSH, "mw_bub");
        idle(EXP_NORM, "mw_norm");
        check_counts("mw", 3, 1);

        // dmem wait in the middle of FLUSH resumes the remaining bubble
        do_reset("reset_mf");
        step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_FLUSH, "mf_br");
        step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, EXP_FREEZE, "mf_w0");
        step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, EXP_FREEZE, "mf_w1");
        step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, EXP_FLUSH, "mf_res");
        idle(EXP_NORM, "mf_norm");
        check_counts("mf", 2, 1);

        // Flush beats load-use; FLUSH bubble also beats load-use; reset aborts FLUSH
        do_reset("reset_pr");
        step(OP_REG, 5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, EXP_FLUSH, "pr_br_lu");
        step(OP_REG, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, EXP_FLUSH, "pr_bub_lu");
        check_counts("pr", 0, 1);
        step(OP_IMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_FLUSH, "pr_br2");
        do_reset("pr_rst_mid");
        idle(EXP_NORM, "pr_run");
        check_counts("pr_rst", 0, 0);

        // Saturation on the 2-bit instance: 3 then stays 3
        do_reset("reset_sat");
        for (int i = 0; i < 5; i++) begin
            step(OP_REG, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, EXP_STALL,
                 $sformatf("sat_lu%0d", i));
            if (i == 2) begin
                @(posedge clk);
                #1;
                check("sat_at3", {30'd0, s_stall}, 32'd3);
            end
        end
        check_counts("sat_main", 5, 0);
        check("sat_hold", {30'd0, s_stall}, 32'd3);
        check("sat_fcnt", {30'd0, s_fcnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
